// File: rtl/interrupt_sequencer_pkg.sv
// Shared processor definitions used by the interrupt entry sequencer:
// FSM state encoding, default parameters, pipeline NOP/bubble constants
// and the stack address helper.
package interrupt_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_PUSH_HI  = 3'd2,
        ST_PUSH_LO  = 3'd3,
        ST_PUSH_CCR = 3'd4,
        ST_VECTOR   = 3'd5
    } seq_state_t;

    localparam int          DRAIN_CYCLES_DEFAULT = 3;
    localparam logic [31:0] INT_VECTOR_DEFAULT   = 32'h0000_0002;

    // Instruction word placed in FD on a flush, and the all-zero control
    // word that makes up a DE bubble.
    localparam logic [15:0] NOP_INSTR   = 16'h0000;
    localparam logic [31:0] BUBBLE_CTRL = 32'h0000_0000;

    // Stack slot 'offset' entries below the captured SP. The subtraction is
    // full 32-bit so that SP=0 wraps to the top of the 12-bit data memory.
    function automatic logic [11:0] stack_slot(input logic [31:0] sp,
                                               input logic [31:0] offset);
        logic [31:0] addr;
        addr = sp - offset;
        return addr[11:0];
    endfunction

endpackage

// File: rtl/drain_counter.sv
// Down-counter that times the pipeline drain before the stack pushes.
// Loads a start value, counts down once per enabled cycle and holds at zero.
module drain_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Count register: reset, load, or saturating decrement.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: drains the pipeline, pushes the return PC
// (high then low half) and the condition flags onto the stack, updates SP
// and redirects fetch to the interrupt vector. Outside an entry sequence it
// passes the load-use stall and branch flush controls straight through.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter int          DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter logic [31:0] INT_VECTOR   = INT_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        int_req,
    input  logic        load_use_stall,
    input  logic        branch_taken,
    input  logic [31:0] pc_cur,
    input  logic [31:0] sp_cur,
    input  logic [4:0]  ccr_cur,
    output logic        fd_en,
    output logic        de_en,
    output logic        flush_fd,
    output logic        flush_de,
    output logic        stk_wr,
    output logic [11:0] stk_addr,
    output logic [15:0] stk_data,
    output logic        sp_wr,
    output logic [31:0] sp_wr_data,
    output logic        pc_load,
    output logic [31:0] pc_load_value,
    output logic        int_ack,
    output logic        busy
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    seq_state_t  state;
    seq_state_t  state_next;
    logic        pending;
    logic [31:0] ret_pc;
    logic [31:0] sp_cap;
    logic        cnt_load;
    logic        cnt_dec;
    logic        cnt_zero;
    logic        capture;

    drain_counter #(
        .WIDTH (CNT_W)
    ) u_drain_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (CNT_W'(DRAIN_CYCLES - 1)),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a request seen while busy waits in 'pending'.
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        capture    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (pending || int_req) begin
                    state_next = ST_DRAIN;
                    cnt_load   = 1'b1;
                end
            end
            ST_DRAIN: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    capture    = 1'b1;
                    state_next = ST_PUSH_HI;
                end
            end
            ST_PUSH_HI:  state_next = ST_PUSH_LO;
            ST_PUSH_LO:  state_next = ST_PUSH_CCR;
            ST_PUSH_CCR: state_next = ST_VECTOR;
            ST_VECTOR:   state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Pending request flag and the return context captured at end of drain.
    // PC is sampled on the last drain cycle so a branch resolved during the
    // drain is what gets pushed as the return address.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            ret_pc  <= '0;
            sp_cap  <= '0;
        end else begin
            pending <= int_req || (pending && !int_ack);
            if (capture) begin
                ret_pc <= pc_cur;
                sp_cap <= sp_cur;
            end
        end
    end

    // Output decode; reset forces the quiet pass-through values so an
    // abandoned sequence issues no further stack writes.
    always_comb begin
        fd_en         = 1'b1;
        de_en         = 1'b1;
        flush_fd      = 1'b0;
        flush_de      = 1'b0;
        stk_wr        = 1'b0;
        stk_addr      = '0;
        stk_data      = '0;
        sp_wr         = 1'b0;
        sp_wr_data    = '0;
        pc_load       = 1'b0;
        pc_load_value = '0;
        int_ack       = 1'b0;
        busy          = 1'b0;
        if (!reset) begin
            unique case (state)
                ST_IDLE: begin
                    fd_en    = !load_use_stall;
                    de_en    = !load_use_stall;
                    flush_de = load_use_stall;
                    flush_fd = branch_taken;
                end
                ST_DRAIN: begin
                    busy     = 1'b1;
                    fd_en    = 1'b0;
                    flush_de = 1'b1;
                    flush_fd = branch_taken;
                end
                ST_PUSH_HI: begin
                    busy     = 1'b1;
                    fd_en    = 1'b0;
                    de_en    = 1'b0;
                    stk_wr   = 1'b1;
                    stk_addr = stack_slot(sp_cap, 32'd0);
                    stk_data = ret_pc[31:16];
                end
                ST_PUSH_LO: begin
                    busy     = 1'b1;
                    fd_en    = 1'b0;
                    de_en    = 1'b0;
                    stk_wr   = 1'b1;
                    stk_addr = stack_slot(sp_cap, 32'd1);
                    stk_data = ret_pc[15:0];
                end
                ST_PUSH_CCR: begin
                    busy       = 1'b1;
                    fd_en      = 1'b0;
                    de_en      = 1'b0;
                    stk_wr     = 1'b1;
                    stk_addr   = stack_slot(sp_cap, 32'd2);
                    stk_data   = {11'b0, ccr_cur};
                    sp_wr      = 1'b1;
                    sp_wr_data = sp_cap - 32'd3;
                end
                ST_VECTOR: begin
                    busy          = 1'b1;
                    fd_en         = 1'b0;
                    de_en         = 1'b0;
                    pc_load       = 1'b1;
                    pc_load_value = INT_VECTOR;
                    flush_fd      = 1'b1;
                    int_ack       = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer. A reference model tracks the
// entry sequence as a step number (0 = idle, 1..D drain, then three pushes
// and the vector step) and derives every output from that step.
module tb_interrupt_sequencer;

    localparam int          D   = 3;
    localparam logic [31:0] VEC = 32'h0000_0002;

    logic        clk;
    logic        reset;
    logic        int_req;
    logic        load_use_stall;
    logic        branch_taken;
    logic [31:0] pc_cur;
    logic [31:0] sp_cur;
    logic [4:0]  ccr_cur;
    logic        fd_en, de_en, flush_fd, flush_de, stk_wr, sp_wr, pc_load, int_ack, busy;
    logic [11:0] stk_addr;
    logic [15:0] stk_data;
    logic [31:0] sp_wr_data, pc_load_value;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    int          m_phase   = 0;
    logic        m_pending = 1'b0;
    logic [31:0] m_ret_pc  = '0;
    logic [31:0] m_sp_cap  = '0;

    // Observation log.
    logic [11:0] wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          ack_k_q[$];
    logic [31:0] sp_seen;
    logic [31:0] pc_seen;

    logic [100:0] dut_vec;
    assign dut_vec = {fd_en, de_en, flush_fd, flush_de, stk_wr, stk_addr, stk_data,
                      sp_wr, sp_wr_data, pc_load, pc_load_value, int_ack, busy};

    interrupt_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .int_req        (int_req),
        .load_use_stall (load_use_stall),
        .branch_taken   (branch_taken),
        .pc_cur         (pc_cur),
        .sp_cur         (sp_cur),
        .ccr_cur        (ccr_cur),
        .fd_en          (fd_en),
        .de_en          (de_en),
        .flush_fd       (flush_fd),
        .flush_de       (flush_de),
        .stk_wr         (stk_wr),
        .stk_addr       (stk_addr),
        .stk_data       (stk_data),
        .sp_wr          (sp_wr),
        .sp_wr_data     (sp_wr_data),
        .pc_load        (pc_load),
        .pc_load_value  (pc_load_value),
        .int_ack        (int_ack),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model step: entry after an idle cycle with a request, D drain steps,
    // three pushes, one vector step, then back to idle.
    always @(posedge clk) begin
        if (reset) begin
            m_phase   <= 0;
            m_pending <= 1'b0;
            m_ret_pc  <= '0;
            m_sp_cap  <= '0;
        end else begin
            m_pending <= int_req || (m_pending && (m_phase != D + 4));
            if (m_phase == D) begin
                m_ret_pc <= pc_cur;
                m_sp_cap <= sp_cur;
            end
            if (m_phase == 0)          m_phase <= (m_pending || int_req) ? 1 : 0;
            else if (m_phase == D + 4) m_phase <= 0;
            else                       m_phase <= m_phase + 1;
        end
    end

    // Expected outputs for the current model step and current inputs.
    function automatic logic [100:0] model_exp();
        logic fd, de, ffd, fde, sw, spw, pcl, ack, bsy;
        logic [11:0] a;
        logic [15:0] d;
        logic [31:0] spd, pcv, t;
        fd = 1; de = 1; ffd = 0; fde = 0; sw = 0; spw = 0; pcl = 0; ack = 0; bsy = 0;
        a = '0; d = '0; spd = '0; pcv = '0;
        if (!reset) begin
            if (m_phase == 0) begin
                fd  = !load_use_stall;
                de  = !load_use_stall;
                fde = load_use_stall;
                ffd = branch_taken;
            end else begin
                bsy = 1; fd = 0; de = 0;
                if (m_phase <= D) begin
                    de = 1; fde = 1; ffd = branch_taken;
                end else if (m_phase == D + 1) begin
                    sw = 1; a = m_sp_cap[11:0]; d = m_ret_pc[31:16];
                end else if (m_phase == D + 2) begin
                    sw = 1; t = m_sp_cap - 1; a = t[11:0]; d = m_ret_pc[15:0];
                end else if (m_phase == D + 3) begin
                    sw = 1; t = m_sp_cap - 2; a = t[11:0]; d = {11'b0, ccr_cur};
                    spw = 1; spd = m_sp_cap - 3;
                end else begin
                    pcl = 1; pcv = VEC; ffd = 1; ack = 1;
                end
            end
        end
        return {fd, de, ffd, fde, sw, a, d, spw, spd, pcl, pcv, ack, bsy};
    endfunction

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        ack_k_q.delete();
        sp_seen = 'x;
        pc_seen = 'x;
    endtask

    task automatic log_cycle(input int k);
        if (stk_wr === 1'b1) begin
            wr_addr_q.push_back(stk_addr);
            wr_data_q.push_back(stk_data);
        end
        if (sp_wr === 1'b1)   sp_seen = sp_wr_data;
        if (pc_load === 1'b1) pc_seen = pc_load_value;
        if (int_ack === 1'b1) ack_k_q.push_back(k);
    endtask

    task automatic test_reset();
        logic [100:0] exp;
        reset = 1; int_req = 1; load_use_stall = 1; branch_taken = 1;
        pc_cur = 32'h1234_5678; sp_cur = 32'h0000_0800; ccr_cur = 5'h1F;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                reset = 0; int_req = 0; load_use_stall = 0; branch_taken = 0;
            end
            @(negedge clk);
            exp = model_exp();
            tests++;
            if (dut_vec !== exp) begin
                fails++;
                $display("FAIL reset cycle %0d: got %h expected %h", k, dut_vec, exp);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        tests++;
        if ({fd_en, de_en, flush_fd, flush_de, stk_wr, busy} !== 6'b110000) begin
            fails++;
            $display("FAIL reset_after: got %b expected 110000",
                     {fd_en, de_en, flush_fd, flush_de, stk_wr, busy});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_idle_passthrough();
        logic [100:0] exp;
        for (int k = 0; k < 3; k++) begin
            load_use_stall = (k == 0);
            @(negedge clk);
            exp = model_exp();
            tests++;
            if (dut_vec !== exp) begin
                fails++;
                $display("FAIL idle_pass cycle %0d: got %h expected %h", k, dut_vec, exp);
            end
            tests++;
            if ({fd_en, de_en, flush_de, busy} !== ((k == 0) ? 4'b0010 : 4'b1100)) begin
                fails++;
                $display("FAIL idle_pass_ctl cycle %0d: got %b expected %b", k,
                         {fd_en, de_en, flush_de, busy}, (k == 0) ? 4'b0010 : 4'b1100);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_basic_entry();
        logic [100:0] exp;
        logic [27:0]  exp_wr [3];
        exp_wr = '{{12'hFFF, 16'h0001}, {12'hFFE, 16'h2345}, {12'hFFD, 16'h0015}};
        clear_log();
        pc_cur = 32'h0001_2345; sp_cur = 32'h0000_0FFF; ccr_cur = 5'b10101;
        for (int k = 0; k < 10; k++) begin
            int_req = (k == 0);
            @(negedge clk);
            exp = model_exp();
            tests++;
            if (dut_vec !== exp) begin
                fails++;
                $display("FAIL basic_entry cycle %0d: got %h expected %h", k, dut_vec, exp);
            end
            log_cycle(k);
            @(posedge clk); #1;
        end
        tests++;
        if (wr_addr_q.size() != 3) begin
            fails++;
            $display("FAIL basic_wr_count: got %0d expected 3", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if ({wr_addr_q[i], wr_data_q[i]} !== exp_wr[i]) begin
                    fails++;
                    $display("FAIL basic_wr%0d: got %h expected %h", i,
                             {wr_addr_q[i], wr_data_q[i]}, exp_wr[i]);
                end
            end
        end
        tests++;
        if (sp_seen !== 32'h0000_0FFC || pc_seen !== 32'h0000_0002) begin
            fails++;
            $display("FAIL basic_sp_pc: got %h/%h expected 00000ffc/00000002", sp_seen, pc_seen);
        end
        tests++;
        if (ack_k_q.size() != 1 || ack_k_q[0] != 7) begin
            fails++;
            $display("FAIL basic_ack: got %0d acks first at %0d expected 1 at 7",
                     ack_k_q.size(), (ack_k_q.size() > 0) ? ack_k_q[0] : -1);
        end
    endtask

    task automatic test_sp_wrap();
        logic [100:0] exp;
        clear_log();
        pc_cur = 32'hCAFE_0123; sp_cur = 32'h0000_0000; ccr_cur = 5'b00011;
        for (int k = 0; k < 9; k++) begin
            int_req = (k == 0);
            @(negedge clk);
            exp = model_exp();
            tests++;
            if (dut_vec !== exp) begin
                fails++;
                $display("FAIL sp_wrap cycle %0d: got %h expected %h", k, dut_vec, exp);
            end
            log_cycle(k);
            @(posedge clk); #1;
        end
        tests++;
        if (wr_addr_q.size() != 3 || wr_addr_q[0] !== 12'h000 || wr_addr_q[1] !== 12'hFFF
            || wr_addr_q[2] !== 12'hFFE) begin
            fails++;
            $display("FAIL sp_wrap_addr: got %0d writes %p expected 000 fff ffe",
                     wr_addr_q.size(), wr_addr_q);
        end
        tests++;
        if (sp_seen !== 32'hFFFF_FFFD) begin
            fails++;
            $display("FAIL sp_wrap_sp: got %h expected fffffffd", sp_seen);
        end
    endtask

    task automatic test_branch_in_drain();
        logic [100:0] exp;
        logic         ffd_k1;
        clear_log();
        ffd_k1 = 1'b0;
        pc_cur = 32'h0000_1000; sp_cur = 32'h0000_0400; ccr_cur = 5'b01000;
        for (int k = 0; k < 9; k++) begin
            int_req      = (k == 0);
            branch_taken = (k == 1);
            if (k >= 2) pc_cur = 32'h0000_0040;
            @(negedge clk);
            exp = model_exp();
            tests++;
            if (dut_vec !== exp) begin
                fails++;
                $display("FAIL branch_drain cycle %0d: got %h expected %h", k, dut_vec, exp);
            end
            if (k == 1) ffd_k1 = flush_fd;
            log_cycle(k);
            @(posedge clk); #1;
        end
        branch_taken = 0;
        tests++;
        if (ffd_k1 !== 1'b1) begin
            fails++;
            $display("FAIL branch_flush_fd: got %b expected 1", ffd_k1);
        end
        tests++;
        if (wr_data_q.size() != 3 || wr_data_q[0] !== 16'h0000 || wr_data_q[1] !== 16'h0040) begin
            fails++;
            $display("FAIL branch_ret_pc: got %p expected 0000 0040 ...", wr_data_q);
        end
    endtask

    task automatic test_back_to_back();
        logic [100:0] exp;
        logic [2:0]   k0_obs, k8_obs;
        logic         k9_busy;
        clear_log();
        pc_cur = 32'h0000_2000; sp_cur = 32'h0000_0900; ccr_cur = 5'b11111;
        for (int k = 0; k < 26; k++) begin
            int_req        = (k <= 13);
            branch_taken   = (k == 0);
            load_use_stall = (k == 0);
            @(negedge clk);
            exp = model_exp();
            tests++;
            if (dut_vec !== exp) begin
                fails++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", k, dut_vec, exp);
            end
            if (k == 0) k0_obs = {flush_fd, flush_de, busy};
            if (k == 8) k8_obs = {busy, stk_wr, int_ack};
            if (k == 9) k9_busy = busy;
            log_cycle(k);
            @(posedge clk); #1;
        end
        branch_taken = 0; load_use_stall = 0; int_req = 0;
        tests++;
        if (k0_obs !== 3'b110) begin
            fails++;
            $display("FAIL b2b_entry_flush: got %b expected 110", k0_obs);
        end
        tests++;
        if (k8_obs !== 3'b000 || k9_busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_reentry: got %b/%b expected 000/1", k8_obs, k9_busy);
        end
        tests++;
        if (ack_k_q.size() != 2 || ack_k_q[0] != 7 || ack_k_q[1] != 15) begin
            fails++;
            $display("FAIL b2b_acks: got %0d acks %p expected 2 at 7 15", ack_k_q.size(), ack_k_q);
        end
    endtask

    task automatic test_reset_mid_sequence();
        logic [100:0] exp;
        logic [2:0]   k5_obs, k6_obs;
        clear_log();
        pc_cur = 32'h0003_0004; sp_cur = 32'h0000_0A00; ccr_cur = 5'b00001;
        for (int k = 0; k < 14; k++) begin
            int_req = (k == 0);
            reset   = (k == 5);
            @(negedge clk);
            exp = model_exp();
            tests++;
            if (dut_vec !== exp) begin
                fails++;
                $display("FAIL reset_mid cycle %0d: got %h expected %h", k, dut_vec, exp);
            end
            if (k == 5) k5_obs = {busy, stk_wr, int_ack};
            if (k == 6) k6_obs = {busy, stk_wr, int_ack};
            log_cycle(k);
            @(posedge clk); #1;
        end
        reset = 0;
        tests++;
        if (k5_obs !== 3'b000 || k6_obs !== 3'b000) begin
            fails++;
            $display("FAIL reset_mid_abort: got %b/%b expected 000/000", k5_obs, k6_obs);
        end
        tests++;
        if (wr_addr_q.size() != 1 || ack_k_q.size() != 0) begin
            fails++;
            $display("FAIL reset_mid_writes: got %0d writes %0d acks expected 1 and 0",
                     wr_addr_q.size(), ack_k_q.size());
        end
        clear_log();
        for (int k = 0; k < 9; k++) begin
            int_req = (k == 0);
            @(negedge clk);
            exp = model_exp();
            tests++;
            if (dut_vec !== exp) begin
                fails++;
                $display("FAIL reset_mid_resume cycle %0d: got %h expected %h", k, dut_vec, exp);
            end
            log_cycle(k);
            @(posedge clk); #1;
        end
        tests++;
        if (wr_addr_q.size() != 3 || ack_k_q.size() != 1 || ack_k_q[0] != 7) begin
            fails++;
            $display("FAIL reset_mid_resume_seq: got %0d writes %0d acks expected 3 and 1 at 7",
                     wr_addr_q.size(), ack_k_q.size());
        end
    endtask

    task automatic test_random();
        logic [100:0] exp;
        for (int k = 0; k < 600; k++) begin
            reset          = ($urandom_range(0, 59) == 0);
            int_req        = ($urandom_range(0, 9) == 0);
            load_use_stall = ($urandom_range(0, 3) == 0);
            branch_taken   = ($urandom_range(0, 3) == 0);
            pc_cur         = $urandom;
            sp_cur         = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            ccr_cur        = 5'($urandom);
            @(negedge clk);
            exp = model_exp();
            tests++;
            if (dut_vec !== exp) begin
                fails++;
                $display("FAIL random cycle %0d: got %h expected %h", k, dut_vec, exp);
            end
            @(posedge clk); #1;
        end
        reset = 0; int_req = 0; load_use_stall = 0; branch_taken = 0;
    endtask

    initial begin
        reset = 1; int_req = 0; load_use_stall = 0; branch_taken = 0;
        pc_cur = '0; sp_cur = '0; ccr_cur = '0;
        test_reset();
        test_idle_passthrough();
        test_basic_entry();
        test_sp_wrap();
        test_branch_in_drain();
        test_back_to_back();
        test_reset_mid_sequence();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
